// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types and line geometry.
package lc3b_types;

    localparam int unsigned LC3B_OFFSET_BITS = 4;

    typedef logic [15:0]               lc3b_word;
    typedef logic [127:0]              lc3b_cacheline;
    typedef logic [15:LC3B_OFFSET_BITS] lc3b_line_tag;

endpackage

// File: rtl/eviction_buffer_entry.sv
// Single write-back buffer slot: valid/tag/data registers plus a tag compare.
module eviction_buffer_entry #(
    parameter int unsigned TAG_W  = 12,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [TAG_W-1:0]  load_tag,
    input  logic [DATA_W-1:0] load_data,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              valid,
    output logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] data,
    output logic              hit
);

    // Capture a line on load (load wins over clear), drop it on clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            tag   <= load_tag;
            data  <= load_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    // Lookup hits only a line that is still held.
    always_comb begin
        hit = valid && (lookup_tag == tag);
    end

endmodule

// File: rtl/l1_eviction_buffer.sv
// Single-entry eviction buffer between L1 and L2: absorbs dirty evictions,
// serves reads that hit the buffered line, forwards misses, drains when idle.
module l1_eviction_buffer
    import lc3b_types::*;
#(
    parameter int unsigned OFFSET_BITS = LC3B_OFFSET_BITS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         l1_read,
    input  logic         l1_write,
    input  logic [15:0]  l1_address,
    input  logic [127:0] l1_wdata,
    output logic         l1_resp,
    output logic [127:0] l1_rdata,
    output logic         l2_read,
    output logic         l2_write,
    output logic [15:0]  l2_address,
    output logic [127:0] l2_wdata,
    input  logic         l2_resp,
    input  logic [127:0] l2_rdata,
    output logic         wb_valid,
    output logic         drain_inc
);

    localparam int unsigned TAG_W     = 16 - OFFSET_BITS;
    localparam logic [15:0] LINE_MASK = ~16'((32'd1 << OFFSET_BITS) - 32'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               buf_valid;
    logic [TAG_W-1:0]   buf_tag;
    logic [127:0]       buf_data;
    logic               hit;
    logic               buf_load;
    logic               buf_clear;
    logic [TAG_W-1:0]   req_tag;
    logic [15:0]        req_line_addr;

    assign req_tag       = l1_address[15:OFFSET_BITS];
    assign req_line_addr = l1_address & LINE_MASK;

    eviction_buffer_entry #(
        .TAG_W  (TAG_W),
        .DATA_W (128)
    ) u_entry (
        .clk        (clk),
        .reset      (reset),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_tag   (req_tag),
        .load_data  (l1_wdata),
        .lookup_tag (req_tag),
        .valid      (buf_valid),
        .tag        (buf_tag),
        .data       (buf_data),
        .hit        (hit)
    );

    assign wb_valid = buf_valid;

    // State register; reset abandons any in-flight READ or DRAIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, buffer controls and L1/L2 handshakes; everything quiet in reset.
    always_comb begin
        state_next = state;
        l1_resp    = 1'b0;
        l1_rdata   = '0;
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        l2_address = '0;
        l2_wdata   = '0;
        drain_inc  = 1'b0;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;

        if (!reset) begin
            unique case (state)
                IDLE: begin
                    // Read takes priority over write and over a pending drain.
                    if (l1_read) begin
                        if (hit) begin
                            l1_resp  = 1'b1;
                            l1_rdata = buf_data;
                        end else begin
                            state_next = READ;
                        end
                    end else if (l1_write) begin
                        if (!buf_valid || hit) begin
                            l1_resp  = 1'b1;
                            buf_load = 1'b1;
                        end else begin
                            state_next = DRAIN;
                        end
                    end else if (buf_valid) begin
                        state_next = DRAIN;
                    end
                end
                READ: begin
                    l2_read    = 1'b1;
                    l2_address = req_line_addr;
                    l1_resp    = l2_resp;
                    l1_rdata   = l2_rdata;
                    if (l2_resp) begin
                        state_next = IDLE;
                    end
                end
                DRAIN: begin
                    l2_write   = 1'b1;
                    l2_address = {buf_tag, {OFFSET_BITS{1'b0}}};
                    l2_wdata   = buf_data;
                    if (l2_resp) begin
                        buf_clear  = 1'b1;
                        drain_inc  = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_eviction_buffer.sv
// Scoreboard bench for l1_eviction_buffer: stimulus pushes expected L1 responses
// and L2 transactions; a monitor pops and compares when the DUT presents them.
module tb_l1_eviction_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         l1_read;
    logic         l1_write;
    logic [15:0]  l1_address;
    logic [127:0] l1_wdata;
    logic         l1_resp;
    logic [127:0] l1_rdata;
    logic         l2_read;
    logic         l2_write;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata;
    logic         l2_resp;
    logic [127:0] l2_rdata;
    logic         wb_valid;
    logic         drain_inc;

    typedef struct {
        bit           is_read;
        bit           from_buf;
        logic [127:0] data;
    } l1_exp_t;

    typedef struct {
        bit           is_write;
        logic [15:0]  addr;
        logic [127:0] data;
    } l2_exp_t;

    l1_exp_t l1_q[$];
    l2_exp_t l2_q[$];
    l1_exp_t mon_e1;
    l2_exp_t mon_e2;

    int checks   = 0;
    int failures = 0;
    int l2_lat   = 3;
    logic [127:0] l2_data_next = '0;

    localparam logic [127:0] D0 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [127:0] D1 = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002;
    localparam logic [127:0] D2 = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0123_4567;
    localparam logic [127:0] D3 = 128'h2220_2220_2220_2220_2220_2220_2220_2220;
    localparam logic [127:0] D4 = 128'h5670_0000_5670_0000_5670_0000_5670_0000;
    localparam logic [127:0] D5 = 128'h7777_0000_0000_0000_0000_0000_0000_7777;

    always #5 clk = ~clk;

    l1_eviction_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .l1_read    (l1_read),
        .l1_write   (l1_write),
        .l1_address (l1_address),
        .l1_wdata   (l1_wdata),
        .l1_resp    (l1_resp),
        .l1_rdata   (l1_rdata),
        .l2_read    (l2_read),
        .l2_write   (l2_write),
        .l2_address (l2_address),
        .l2_wdata   (l2_wdata),
        .l2_resp    (l2_resp),
        .l2_rdata   (l2_rdata),
        .wb_valid   (wb_valid),
        .drain_inc  (drain_inc)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // L2 model: answers a held strobe after l2_lat cycles with a one-cycle pulse.
    initial begin
        int cnt;
        cnt      = 0;
        l2_resp  = 1'b0;
        l2_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (l2_resp) begin
                l2_resp  = 1'b0;
                l2_rdata = '0;
                cnt      = 0;
            end else if ((l2_read || l2_write) && !reset) begin
                cnt++;
                if (cnt >= l2_lat) begin
                    l2_resp  = 1'b1;
                    l2_rdata = l2_read ? l2_data_next : '0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: compare every L1 response and L2 completion against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (l1_read && l1_write) begin
                checks++;
                failures++;
                $display("FAIL illegal_rw l1_read and l1_write both high t=%0t", $time);
            end
            if (l1_resp) begin
                if (l1_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL l1_resp_unexpected actual=1 required=0 t=%0t", $time);
                end else begin
                    mon_e1 = l1_q.pop_front();
                    chk1("l1_resp_during_drain", l2_write, 1'b0);
                    if (mon_e1.is_read) begin
                        chk128("l1_rdata", l1_rdata, mon_e1.data);
                        chk1("l2_read_at_resp", l2_read, !mon_e1.from_buf);
                    end
                end
            end
            if (l2_resp) begin
                if (l2_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL l2_txn_unexpected addr=%h write=%b t=%0t",
                             l2_address, l2_write, $time);
                end else begin
                    mon_e2 = l2_q.pop_front();
                    chk1("l2_write", l2_write, mon_e2.is_write);
                    chk1("l2_read", l2_read, !mon_e2.is_write);
                    chk16("l2_address", l2_address, mon_e2.addr);
                    if (mon_e2.is_write) begin
                        chk128("l2_wdata", l2_wdata, mon_e2.data);
                    end
                    chk1("drain_inc", drain_inc, mon_e2.is_write);
                end
            end
        end
    end

    // Issue one L1 request (starting now), hold it until l1_resp, then release.
    task automatic l1_req(input bit rd, input logic [15:0] a, input logic [127:0] d);
        int n;
        l1_read    = rd;
        l1_write   = !rd;
        l1_address = a;
        l1_wdata   = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!l1_resp && n < 300);
        if (!l1_resp) begin
            checks++;
            failures++;
            $display("FAIL l1_resp_timeout addr=%h actual=0 required=1", a);
        end
        @(posedge clk);
        #1;
        l1_read    = 1'b0;
        l1_write   = 1'b0;
        l1_address = '0;
        l1_wdata   = '0;
    endtask

    // Wait (bounded) for the buffer to drain empty.
    task automatic wait_drained(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wb_valid && n < 300);
        chk1(name, wb_valid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        l1_read    = 1'b0;
        l1_write   = 1'b0;
        l1_address = '0;
        l1_wdata   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("reset_wb_valid", wb_valid, 1'b0);
        chk1("reset_l1_resp", l1_resp, 1'b0);
        chk1("reset_l2_read", l2_read, 1'b0);
        chk1("reset_l2_write", l2_write, 1'b0);
        chk1("reset_drain_inc", drain_inc, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Write into empty buffer, read hit, read miss beats drain, then drain.
        l1_q.push_back('{is_read: 1'b0, from_buf: 1'b0, data: '0});
        l1_req(1'b0, 16'h1234, D0);
        chk1("wb_valid_after_write", wb_valid, 1'b1);
        l2_lat       = 5;
        l2_data_next = D1;
        l1_q.push_back('{is_read: 1'b1, from_buf: 1'b1, data: D0});
        l1_req(1'b1, 16'h1238, '0);
        l2_q.push_back('{is_write: 1'b0, addr: 16'h4560, data: '0});
        l1_q.push_back('{is_read: 1'b1, from_buf: 1'b0, data: D1});
        l1_req(1'b1, 16'h4560, '0);
        l2_q.push_back('{is_write: 1'b1, addr: 16'h1230, data: D0});
        wait_drained("drain_a_empty");

        // Conflicting write forces a drain of the old line before acceptance.
        l2_lat = 3;
        l1_q.push_back('{is_read: 1'b0, from_buf: 1'b0, data: '0});
        l1_req(1'b0, 16'h1230, D0);
        l2_q.push_back('{is_write: 1'b1, addr: 16'h1230, data: D0});
        l1_q.push_back('{is_read: 1'b0, from_buf: 1'b0, data: '0});
        l1_req(1'b0, 16'h2220, D3);
        chk1("wb_valid_after_conflict", wb_valid, 1'b1);
        l2_q.push_back('{is_write: 1'b1, addr: 16'h2220, data: D3});
        wait_drained("drain_b_empty");

        // Same-line overwrite coalesces; the drain carries the newer data.
        l1_q.push_back('{is_read: 1'b0, from_buf: 1'b0, data: '0});
        l1_req(1'b0, 16'h1230, D0);
        l1_q.push_back('{is_read: 1'b0, from_buf: 1'b0, data: '0});
        l1_req(1'b0, 16'h1230, D2);
        l2_q.push_back('{is_write: 1'b1, addr: 16'h1230, data: D2});
        wait_drained("drain_c_empty");

        // Reset in the middle of a drain discards the line.
        l2_lat = 100;
        l1_q.push_back('{is_read: 1'b0, from_buf: 1'b0, data: '0});
        l1_req(1'b0, 16'h5670, D4);
        n = 0;
        while (!l2_write && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1("drain_d_started", l2_write, 1'b1);
        chk16("drain_d_address", l2_address, 16'h5670);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk1("mid_drain_reset_l2_write", l2_write, 1'b0);
        chk1("mid_drain_reset_wb_valid", wb_valid, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk1("post_reset_l2_write", l2_write, 1'b0);
        chk1("post_reset_wb_valid", wb_valid, 1'b0);
        chk1("post_reset_l1_resp", l1_resp, 1'b0);

        // Normal operation after reset.
        @(posedge clk);
        #1;
        l2_lat = 2;
        l1_q.push_back('{is_read: 1'b0, from_buf: 1'b0, data: '0});
        l1_req(1'b0, 16'h7775, D5);
        l2_q.push_back('{is_write: 1'b1, addr: 16'h7770, data: D5});
        wait_drained("drain_e_empty");

        repeat (3) @(negedge clk);
        chk16("l1_queue_empty", 16'(l1_q.size()), 16'd0);
        chk16("l2_queue_empty", 16'(l2_q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound so the bench can never hang.
    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
